// File: rtl/smart_mac_multi_if.sv
// smart_mac_multi_if: CPU/memory-side bus seen by the multi-region access controller
interface smart_mac_multi_if #(
  parameter int NUM_REGIONS = 2,
  parameter int ADDR_W      = 16
);
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_en;
  logic [15:0]            mem_din;
  logic [15:0]            ins_addr;
  logic                   disable_debug;
  logic [15:0]            mem_dout;
  logic                   reset;
  logic [NUM_REGIONS-1:0] in_safe_area;
  logic                   viol_valid;
  logic [1:0]             viol_region;
  logic                   viol_type;
  modport master (
    output mem_addr, mem_en, mem_din, ins_addr, disable_debug,
    input  mem_dout, reset, in_safe_area, viol_valid, viol_region, viol_type
  );
  modport slave (
    input  mem_addr, mem_en, mem_din, ins_addr, disable_debug,
    output mem_dout, reset, in_safe_area, viol_valid, viol_region, viol_type
  );
endinterface

// File: rtl/smart_mac_multi.sv
// smart_mac_multi: guards NUM_REGIONS code/data regions, resets the device on illegal access or entry
module smart_mac_multi #(
  parameter int                       NUM_REGIONS  = 2,
  parameter int                       ADDR_W       = 16,
  parameter logic [NUM_REGIONS*16-1:0] CODE_LOW    = {16'hE200, 16'hE000},
  parameter logic [NUM_REGIONS*16-1:0] CODE_HIGH   = {16'hE2FF, 16'hE0FF},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] DATA_LOW  = {16'h0280, 16'h0200},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] DATA_HIGH = {16'h02FF, 16'h027F},
  parameter int                       STRICT_ENTRY = 1,
  parameter int                       RESET_CYCLES = 4
) (
  input logic              mclk,
  input logic              puc_rst,
  smart_mac_multi_if.slave bus
);
  typedef enum logic {IDLE, RST} state_t;
  state_t                 state_q, state_d;
  logic [NUM_REGIONS-1:0] act_q, act_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   viol_valid_q, viol_valid_d;
  logic [1:0]             viol_region_q, viol_region_d;
  logic                   viol_type_q, viol_type_d;
  logic [NUM_REGIONS-1:0] code_hit, at_entry, data_hit, data_v, entry_v;
  logic                   any_v, sel_type;
  logic [1:0]             sel_idx;
  // all checks use the pre-update act_q, so a data access on the entry fetch itself still violates
  always_comb begin
    sel_idx  = '0;
    sel_type = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      code_hit[i] = bus.ins_addr >= CODE_LOW[i*16 +: 16] && bus.ins_addr <= CODE_HIGH[i*16 +: 16];
      at_entry[i] = bus.ins_addr == CODE_LOW[i*16 +: 16];
      data_hit[i] = bus.mem_en && bus.mem_addr >= DATA_LOW[i*ADDR_W +: ADDR_W]
                    && bus.mem_addr <= DATA_HIGH[i*ADDR_W +: ADDR_W];
      data_v[i]   = data_hit[i] & ~act_q[i];
      entry_v[i]  = (STRICT_ENTRY != 0) & code_hit[i] & ~at_entry[i] & ~act_q[i];
    end
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (data_v[i] | entry_v[i]) begin
        sel_idx  = 2'(i);
        sel_type = ~data_v[i];
      end
    end
    any_v = |(data_v | entry_v);
  end
  always_comb begin
    state_d       = state_q;
    act_d         = act_q;
    cnt_d         = cnt_q;
    viol_valid_d  = viol_valid_q;
    viol_region_d = viol_region_q;
    viol_type_d   = viol_type_q;
    if (state_q == RST) begin
      act_d   = '0;
      cnt_d   = cnt_q - 8'd1;
      state_d = (cnt_q == 8'd0) ? IDLE : RST;
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++)
        act_d[i] = at_entry[i] ? 1'b1 : code_hit[i] ? act_q[i] : 1'b0;
      if (any_v && !viol_valid_q) begin
        viol_valid_d  = 1'b1;
        viol_region_d = sel_idx;
        viol_type_d   = sel_type;
      end
      if (any_v && !bus.disable_debug) begin
        state_d = RST;
        cnt_d   = 8'(RESET_CYCLES - 1);
        act_d   = '0;
      end
    end
  end
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q       <= IDLE;
      act_q         <= '0;
      cnt_q         <= '0;
      viol_valid_q  <= 1'b0;
      viol_region_q <= '0;
      viol_type_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      cnt_q         <= cnt_d;
      viol_valid_q  <= viol_valid_d;
      viol_region_q <= viol_region_d;
      viol_type_q   <= viol_type_d;
    end
  end
  assign bus.reset        = state_q == RST;
  assign bus.mem_dout     = (bus.reset || (|data_v && !bus.disable_debug)) ? 16'h0000 : bus.mem_din;
  assign bus.in_safe_area = act_q;
  assign bus.viol_valid   = viol_valid_q;
  assign bus.viol_region  = viol_region_q;
  assign bus.viol_type    = viol_type_q;
endmodule

// File: tb/tb_smart_mac_multi.sv
// tb_smart_mac_multi: directed plan scenarios plus random traffic checked against a behavioural model
module tb_smart_mac_multi;
  logic mclk = 1'b0;
  logic puc_rst;
  int   n_cmp = 0;
  int   n_err = 0;
  smart_mac_multi_if #(.NUM_REGIONS(2), .ADDR_W(16)) bus ();
  smart_mac_multi dut (.mclk(mclk), .puc_rst(puc_rst), .bus(bus));
  always #5 mclk = ~mclk;
  logic [15:0] cl[2] = '{16'hE000, 16'hE200};
  logic [15:0] ch[2] = '{16'hE0FF, 16'hE2FF};
  logic [15:0] dl[2] = '{16'h0200, 16'h0280};
  logic [15:0] dh[2] = '{16'h027F, 16'h02FF};
  bit m_act[2];
  int m_left;
  bit m_vv;
  int m_vr;
  bit m_vt;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [15:0] ia, input logic en, input logic [15:0] ma,
                      input logic dd, input logic pr, input logic [15:0] din);
    bit dv[2], ev[2], hit[2];
    int w;
    bus.ins_addr = ia; bus.mem_en = en; bus.mem_addr = ma;
    bus.disable_debug = dd; bus.mem_din = din; puc_rst = pr;
    #1;
    for (int i = 0; i < 2; i++) begin
      hit[i] = ia >= cl[i] && ia <= ch[i];
      dv[i]  = en && ma >= dl[i] && ma <= dh[i] && !m_act[i];
      ev[i]  = hit[i] && ia != cl[i] && !m_act[i];
    end
    check("dout", bus.mem_dout, (m_left > 0 || ((dv[0] || dv[1]) && !dd)) ? 16'h0 : din);
    check("reset", bus.reset, m_left > 0);
    check("safe", bus.in_safe_area, {m_act[1], m_act[0]});
    check("vvalid", bus.viol_valid, m_vv);
    check("vregion", bus.viol_region, m_vr);
    check("vtype", bus.viol_type, m_vt);
    @(posedge mclk);
    if (pr) begin
      m_act = '{0, 0}; m_left = 0; m_vv = 0; m_vr = 0; m_vt = 0;
    end else if (m_left > 0) begin
      m_left--;
      m_act = '{0, 0};
    end else begin
      w = -1;
      for (int i = 0; i < 2; i++) if (w < 0 && (dv[i] || ev[i])) w = i;
      if (w >= 0 && !m_vv) begin
        m_vv = 1; m_vr = w; m_vt = !dv[w];
      end
      if (w >= 0 && !dd) begin
        m_left = 4;
        m_act = '{0, 0};
      end else begin
        for (int i = 0; i < 2; i++) m_act[i] = (ia == cl[i]) ? 1'b1 : hit[i] ? m_act[i] : 1'b0;
      end
    end
    @(negedge mclk);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(16'h4000, 0, 16'h0000, 0, 0, 16'(k + 16'h1234));
  endtask
  function automatic logic [15:0] pick_ia();
    logic [15:0] t[9] = '{16'hE000, 16'hE002, 16'hE0FF, 16'hE100, 16'hE200,
                          16'hE210, 16'hE2FF, 16'h4000, 16'h0000};
    int k = $urandom_range(0, 9);
    return (k == 9) ? 16'($urandom) : t[k];
  endfunction
  function automatic logic [15:0] pick_ma();
    logic [15:0] t[6] = '{16'h01FF, 16'h0200, 16'h027F, 16'h0280, 16'h02FF, 16'h0300};
    int k = $urandom_range(0, 6);
    return (k == 6) ? 16'($urandom) : t[k];
  endfunction
  initial begin
    bus.ins_addr = 16'h4000; bus.mem_en = 0; bus.mem_addr = 0;
    bus.disable_debug = 0; bus.mem_din = 0; puc_rst = 1;
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    puc_rst = 0;
    // legal entry then in-region read
    step(16'hE000, 0, 16'h0000, 0, 0, 16'hAAAA);
    step(16'hE002, 1, 16'h0210, 0, 0, 16'h5A5A);
    check("legal_safe", bus.in_safe_area, 2'b01);
    // data violation on region 1 from outside code
    step(16'h4000, 1, 16'h0290, 0, 0, 16'hBEEF);
    idle(6);
    check("dv_region", bus.viol_region, 2'd1);
    // illegal mid-region entry into region 0
    step(16'h4000, 0, 16'h0000, 0, 1, 16'h0);
    step(16'hE010, 0, 16'h0000, 0, 0, 16'h1111);
    idle(6);
    check("entry_type", bus.viol_type, 1'b1);
    // simultaneous violations, plus one more ignored during the pulse
    step(16'h4000, 0, 16'h0000, 0, 1, 16'h0);
    step(16'hE210, 1, 16'h0210, 0, 0, 16'h2222);
    step(16'hE010, 1, 16'h0290, 0, 0, 16'h3333);
    idle(5);
    check("sim_type", bus.viol_type, 1'b0);
    // debug bypass
    step(16'h4000, 0, 16'h0000, 0, 1, 16'h0);
    step(16'h4000, 1, 16'h0200, 1, 0, 16'h4444);
    idle(2);
    // puc_rst on the second pulse cycle
    step(16'h4000, 0, 16'h0000, 0, 1, 16'h0);
    step(16'h4000, 1, 16'h0200, 0, 0, 16'h5555);
    step(16'h4000, 0, 16'h0000, 0, 0, 16'h6666);
    step(16'h4000, 0, 16'h0000, 0, 1, 16'h7777);
    step(16'hE000, 0, 16'h0000, 0, 0, 16'h8888);
    check("abort_reset", bus.reset, 1'b0);
    for (int k = 0; k < 600; k++)
      step(pick_ia(), 1'($urandom), pick_ma(), $urandom_range(0, 7) == 0,
           $urandom_range(0, 49) == 0, 16'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/smart_mac_multi.md
Name: smart_mac_multi

Overview:
- Parametrised successor to the single-region memory access controller.
- Guards NUM_REGIONS independent protected regions. Each region has a code range, a single legal entry point and a protected data range.
- Protected data may be touched only while execution sits inside the owning code region. Optionally, a code region may be entered only through its entry point (its low address).
- Violations hold the device in reset for a programmable number of cycles, mask the offending read, and are logged in sticky cause registers.

Parameters:
- NUM_REGIONS, 2, number of protected regions (1..4).
- ADDR_W, 16, width of mem_addr.
- CODE_LOW, {16'hE200,16'hE000}, packed NUM_REGIONS*16 vector; region i entry point and code low bound; region 0 in bits [15:0].
- CODE_HIGH, {16'hE2FF,16'hE0FF}, packed NUM_REGIONS*16 vector; code high bound, inclusive.
- DATA_LOW, {16'h0280,16'h0200}, packed NUM_REGIONS*ADDR_W vector; protected data low bound.
- DATA_HIGH, {16'h02FF,16'h027F}, packed NUM_REGIONS*ADDR_W vector; protected data high bound, inclusive.
- STRICT_ENTRY, 1, when 1 a mid-region entry is a violation.
- RESET_CYCLES, 4, length of the reset pulse (1..255).

Ports:
- mclk  input  1  memory/system clock
- puc_rst  input  1  synchronous active-high reset
- mem_addr  input  ADDR_W  memory address
- mem_en  input  1  memory access strobe (read or write) this cycle
- mem_din  input  16  memory data from RAM
- ins_addr  input  16  current instruction address
- disable_debug  input  1  high: violations logged but no reset and no masking
- mem_dout  output  16  data to CPU (masked on violation)
- reset  output  1  high to reset the device
- in_safe_area  output  NUM_REGIONS  per-region "executing inside" flags
- viol_valid  output  1  sticky: a violation has been logged
- viol_region  output  2  index of the logged region
- viol_type  output  1  0 = data access, 1 = illegal entry

Behaviour:
- All state is updated on posedge mclk. puc_rst=1 clears act[], the FSM (to IDLE), the counter, reset, viol_valid, viol_region and viol_type to 0.
- Hit definitions, inclusive range compares on the current inputs:
  - code_hit[i] = CODE_LOW[i] <= ins_addr <= CODE_HIGH[i]
  - data_hit[i] = mem_en & DATA_LOW[i] <= mem_addr <= DATA_HIGH[i]
- Region tracking, act[i] (registered, drives in_safe_area[i]), in IDLE:
  - ins_addr==CODE_LOW[i] -> 1
  - else ~code_hit[i] -> 0
  - else hold
- Violation checks always use the pre-update act[i]:
  - data_v[i] = data_hit[i] & ~act[i]
  - entry_v[i] = STRICT_ENTRY & code_hit[i] & ins_addr!=CODE_LOW[i] & ~act[i]
  - Consequence: a data access in the same cycle as the entry fetch is a violation.
- Selection: the lowest-index region wins. Within a region, data_v has priority over entry_v.
- FSM IDLE:
  - Any violation with disable_debug=0 -> go to RST; load cnt=RESET_CYCLES-1; clear all act[]; reset=1 from the next cycle.
  - If viol_valid=0, latch viol_region and viol_type and set viol_valid=1. Otherwise keep the first logged cause (sticky until puc_rst).
  - With disable_debug=1, violations are logged the same way; no state change, no reset.
- FSM RST:
  - reset=1; act[] held at 0; all violations ignored (not logged).
  - cnt decrements each cycle; when cnt==0, go to IDLE with reset=0 the following cycle.
  - Pulse width is exactly RESET_CYCLES cycles.
- disable_debug rising while in RST: the pulse runs to completion; it is not truncated.
- puc_rst in any state: immediate return to reset values on that edge; an in-flight pulse is aborted.
- mem_dout:
  - 16'h0000 when reset=1, or combinationally when any data_v[i] & ~disable_debug in the current cycle.
  - Otherwise mem_din, zero latency.
- Overlapping regions: each region is evaluated independently. The spec permits overlap; the priority rules above resolve it.

Test Plan:
- Legal entry: ins_addr 16'hE000 then 16'hE002, read 16'h0210 -> in_safe_area=2'b01, mem_dout=mem_din, reset stays 0.
- Data violation: ins_addr 16'h4000, read 16'h0290 -> mem_dout=0 that cycle; reset=1 for exactly 4 cycles starting the next cycle; viol_region=1, viol_type=0, viol_valid=1.
- Illegal entry (STRICT_ENTRY=1): jump straight to ins_addr 16'hE010 -> reset pulse of 4 cycles; viol_region=0, viol_type=1. With STRICT_ENTRY=0 there is no violation, and a read of 16'h0210 then violates.
- Simultaneous violations: read 16'h0210 while jumping to 16'hE210 -> log region 0 type 0. A second violation during RST is ignored; viol_* remain unchanged after the pulse.
- Debug bypass: disable_debug=1, read 16'h0200 from ins_addr 16'h4000 -> reset=0, mem_dout=mem_din, viol_valid=1, viol_region=0.
- Reset mid-pulse: assert puc_rst on the 2nd RST cycle -> next cycle reset=0, viol_valid=0, in_safe_area=0, FSM in IDLE.
